sample_voice_sequencer: RTL
===========================

SAMPLE_VOICE_SEQUENCER -- requirements
Module: sample_voice_sequencer

Interface
REQ-001 Parameter NUM_VOICES, default 8: number of gate-driven voices sharing one sample BRAM.
REQ-002 Parameter BRAM_DEPTH, default 8192: samples per BRAM.
REQ-003 Parameter ADDR_WIDTH, default 13: BRAM address width, equal to log2(BRAM_DEPTH).
REQ-004 Parameter DATA_WIDTH, default 8: signed sample width.
REQ-005 Parameter BRAM_LATENCY, default 2: cycles from bram_en/bram_addr to valid bram_dout.
REQ-006 clk_in  input  1: the only clock; all logic is on its rising edge.
REQ-007 rst_n_in  input  1: reset, asynchronous and active-low.
REQ-008 sample_tick  input  1: single-cycle pulse requesting one output frame.
REQ-009 gate_in  input  NUM_VOICES: per-voice gate, 1 = voice active.
REQ-010 bram_dout  input  DATA_WIDTH: signed BRAM read data.
REQ-011 bram_en  output  1: registered BRAM read enable.
REQ-012 bram_addr  output  ADDR_WIDTH: registered BRAM read address.
REQ-013 mix_out  output  DATA_WIDTH+$clog2(NUM_VOICES): signed sum of the active voices' samples for the last frame.
REQ-014 mix_valid  output  1: one-cycle pulse when mix_out updates.
REQ-015 busy  output  1: high whenever the state is not IDLE.
REQ-016 overrun  output  1: sticky flag, set when a sample_tick is dropped.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-018 IDLE: on sample_tick, latch gate_in into gate_snap, clear the accumulator, set voice index v=0, and go to ISSUE.
REQ-019 At the frame start, every voice with gate_in[v]=0 SHALL have its address cleared to 0.
REQ-020 ISSUE: one cycle per voice, v = 0..NUM_VOICES-1 in ascending order, exactly NUM_VOICES cycles.
REQ-021 ISSUE with gate_snap[v]=1: drive bram_en=1 and bram_addr=addr[v].
 - Then addr[v] increments, wrapping BRAM_DEPTH-1 -> 0.
 - Push a valid tag into a BRAM_LATENCY-deep tag pipeline.
REQ-022 ISSUE with gate_snap[v]=0: drive bram_en=0, push an invalid tag, and leave addr[v] unchanged.
REQ-023 DRAIN SHALL last BRAM_LATENCY cycles; then go to DONE.
REQ-024 Whenever the tag at the end of the pipeline is valid, add sign-extended bram_dout to the accumulator, in any state; the accumulator SHALL never overflow at its width.
REQ-025 DONE: mix_out <= accumulator, pulse mix_valid for exactly one cycle, then return to IDLE.
REQ-026 mix_valid SHALL be asserted exactly NUM_VOICES+BRAM_LATENCY+2 cycles after the cycle in which the tick was accepted.
REQ-027 With gate_snap all zero: no BRAM reads occur, mix_out=0, and mix_valid still pulses.
REQ-028 A sample_tick while busy=1 SHALL be ignored and SHALL set overrun; the frame in progress is unaffected.
REQ-029 gate_in changes during a frame SHALL have no effect until the next accepted tick.
REQ-030 bram_en SHALL be 0 in IDLE, DRAIN and DONE.
REQ-031 Addresses of voices not read in a frame SHALL hold their value.

Reset
REQ-032 While rst_n_in=0 the block SHALL hold these values: state=IDLE, every addr[v]=0, bram_en=0, bram_addr=0, mix_out=0, mix_valid=0, busy=0, overrun=0, all tags invalid, accumulator=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no mix_valid pulse; the first tick after release SHALL start a fresh frame.

Structure
REQ-034 Package sample_pkg SHALL hold the following, shared with the other sample-path blocks:
 - default constants NUM_VOICES, BRAM_DEPTH, ADDR_WIDTH, DATA_WIDTH, BRAM_LATENCY;
 - the sequencer state enum typedef.
REQ-035 The per-voice address registers SHALL be one sub-module, voice_addr_bank, which supports:
 - a clear-by-mask input;
 - an increment-one-index input;
 - a read-index port.

Verification
REQ-036 Reset, then tick with gate_in=8'b0000_0001 and BRAM[0]=5 -> one read at address 0; mix_out=5 and mix_valid exactly 12 cycles after the tick; addr[0]=1.
REQ-037 gate_in=8'hFF and every BRAM word equal to -128 -> 8 reads at cycles 1..8 of the frame; mix_out=-1024 with no overflow.
REQ-038 Preload addr[2]=8191, gate_in=8'h04, tick -> read at address 8191; then addr[2]=0, and the next frame reads address 0.
REQ-039 Second tick 3 cycles after the first -> only one mix_valid pulse, overrun=1 until reset, and the first frame's mix_out is correct.
REQ-040 Voice 3 gated for 10 frames, then gate_in[3]=0 at one tick, then 1 at the next -> the later read uses address 0.
REQ-041 rst_n_in pulsed low in DRAIN -> no mix_valid pulse and all outputs at reset values; the next tick completes a normal frame.

Source files
------------

// File: rtl/sample_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_pkg
// Description : Shared defaults and sequencer state type for the sample path.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_pkg;

    localparam int c_NUM_VOICES   = 8;
    localparam int c_BRAM_DEPTH   = 8192;
    localparam int c_ADDR_WIDTH   = 13;
    localparam int c_DATA_WIDTH   = 8;
    localparam int c_BRAM_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage : sample_pkg
`default_nettype wire

// File: rtl/voice_addr_bank.sv
`default_nettype none
// ============================================================================
// Module      : voice_addr_bank
// Description : Per-voice BRAM read pointers with clear-by-mask, single-index
//               wrapping increment and an indexed read port.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_addr_bank
    import sample_pkg::*;
#(
    parameter int NUM_VOICES = c_NUM_VOICES,
    parameter int BRAM_DEPTH = c_BRAM_DEPTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    localparam int IDX_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [NUM_VOICES-1:0] i_clr_mask,
    input  logic                  i_inc_en,
    input  logic [IDX_WIDTH-1:0]  i_inc_idx,
    input  logic [IDX_WIDTH-1:0]  i_rd_idx,
    output logic [ADDR_WIDTH-1:0] o_rd_addr
);

    logic [ADDR_WIDTH-1:0] r_addr_q [NUM_VOICES];
    logic [ADDR_WIDTH-1:0] w_addr_d [NUM_VOICES];

    // Clear has priority: a voice cleared at frame start is never read that frame.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_addr_d[v] = r_addr_q[v];
            if (i_clr_mask[v]) begin
                w_addr_d[v] = '0;
            end else if (i_inc_en && (i_inc_idx == IDX_WIDTH'(v))) begin
                w_addr_d[v] = (r_addr_q[v] == ADDR_WIDTH'(BRAM_DEPTH - 1)) ?
                              '0 : r_addr_q[v] + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_addr_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_addr_q[v] <= w_addr_d[v];
            end
        end
    end

    assign o_rd_addr = r_addr_q[i_rd_idx];

endmodule : voice_addr_bank
`default_nettype wire

// File: rtl/sample_voice_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sample_voice_sequencer
// Description : Per-tick frame sequencer: reads one sample per gated voice from
//               a shared BRAM and emits the signed mix of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_voice_sequencer
    import sample_pkg::*;
#(
    parameter int NUM_VOICES   = c_NUM_VOICES,
    parameter int BRAM_DEPTH   = c_BRAM_DEPTH,
    parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
    parameter int DATA_WIDTH   = c_DATA_WIDTH,
    parameter int BRAM_LATENCY = c_BRAM_LATENCY
) (
    input  logic                                                clk_in,
    input  logic                                                rst_n_in,
    input  logic                                                sample_tick,
    input  logic [NUM_VOICES-1:0]                               gate_in,
    input  logic signed [DATA_WIDTH-1:0]                        bram_dout,
    output logic                                                bram_en,
    output logic [ADDR_WIDTH-1:0]                               bram_addr,
    output logic signed [DATA_WIDTH+$clog2(NUM_VOICES)-1:0]     mix_out,
    output logic                                                mix_valid,
    output logic                                                busy,
    output logic                                                overrun
);

    localparam int MIX_WIDTH = DATA_WIDTH + $clog2(NUM_VOICES);
    localparam int IDX_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int DRN_WIDTH = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

    seq_state_t                   r_state_q, w_state_d;
    logic [IDX_WIDTH-1:0]         r_vidx_q, w_vidx_d, w_vidx_next;
    logic [DRN_WIDTH-1:0]         r_drain_q, w_drain_d;
    logic [NUM_VOICES-1:0]        r_gate_q, w_gate_d;
    logic                         r_bram_en_q, w_bram_en_d;
    logic [ADDR_WIDTH-1:0]        r_bram_addr_q, w_bram_addr_d;
    logic [BRAM_LATENCY-1:0]      r_tag_q, w_tag_d;
    logic signed [MIX_WIDTH-1:0]  r_acc_q, w_acc_d;
    logic signed [MIX_WIDTH-1:0]  r_mix_q, w_mix_d;
    logic                         r_mix_valid_q, w_mix_valid_d;
    logic                         r_busy_q, w_busy_d;
    logic                         r_overrun_q, w_overrun_d;

    logic [NUM_VOICES-1:0]        w_clr_mask;
    logic                         w_inc_en;
    logic [IDX_WIDTH-1:0]         w_rd_idx;
    logic [ADDR_WIDTH-1:0]        w_rd_addr;

    voice_addr_bank #(
        .NUM_VOICES (NUM_VOICES),
        .BRAM_DEPTH (BRAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_bank (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .i_clr_mask (w_clr_mask),
        .i_inc_en   (w_inc_en),
        .i_inc_idx  (r_vidx_q),
        .i_rd_idx   (w_rd_idx),
        .o_rd_addr  (w_rd_addr)
    );

    assign w_vidx_next = r_vidx_q + IDX_WIDTH'(1);

    always_comb begin
        w_state_d     = r_state_q;
        w_vidx_d      = r_vidx_q;
        w_drain_d     = r_drain_q;
        w_gate_d      = r_gate_q;
        w_bram_en_d   = 1'b0;
        w_bram_addr_d = r_bram_addr_q;
        w_acc_d       = r_acc_q;
        w_mix_d       = r_mix_q;
        w_mix_valid_d = 1'b0;
        w_overrun_d   = r_overrun_q;
        w_clr_mask    = '0;
        w_inc_en      = 1'b0;
        w_rd_idx      = '0;

        // The tag at the pipe end marks the cycle its sample sits on bram_dout.
        w_tag_d    = '0;
        w_tag_d[0] = r_bram_en_q;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            w_tag_d[i] = r_tag_q[i-1];
        end
        if (r_tag_q[BRAM_LATENCY-1]) begin
            w_acc_d = r_acc_q + MIX_WIDTH'(bram_dout);
        end

        if (sample_tick && (r_state_q != ST_IDLE)) begin
            w_overrun_d = 1'b1;
        end

        // Enable/address are set up one edge early so each ISSUE cycle presents its voice.
        case (r_state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    w_state_d   = ST_ISSUE;
                    w_gate_d    = gate_in;
                    w_vidx_d    = '0;
                    w_acc_d     = '0;
                    w_clr_mask  = ~gate_in;
                    w_rd_idx    = '0;
                    w_bram_en_d = gate_in[0];
                    if (gate_in[0]) begin
                        w_bram_addr_d = w_rd_addr;
                    end
                end
            end
            ST_ISSUE: begin
                w_inc_en = r_gate_q[r_vidx_q];
                if (r_vidx_q == IDX_WIDTH'(NUM_VOICES - 1)) begin
                    w_state_d = ST_DRAIN;
                    w_drain_d = '0;
                end else begin
                    w_vidx_d    = w_vidx_next;
                    w_rd_idx    = w_vidx_next;
                    w_bram_en_d = r_gate_q[w_vidx_next];
                    if (r_gate_q[w_vidx_next]) begin
                        w_bram_addr_d = w_rd_addr;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drain_q == DRN_WIDTH'(BRAM_LATENCY - 1)) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_drain_d = r_drain_q + DRN_WIDTH'(1);
                end
            end
            ST_DONE: begin
                w_mix_d       = r_acc_q;
                w_mix_valid_d = 1'b1;
                w_state_d     = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state_q     <= ST_IDLE;
            r_vidx_q      <= '0;
            r_drain_q     <= '0;
            r_gate_q      <= '0;
            r_bram_en_q   <= 1'b0;
            r_bram_addr_q <= '0;
            r_tag_q       <= '0;
            r_acc_q       <= '0;
            r_mix_q       <= '0;
            r_mix_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_overrun_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_vidx_q      <= w_vidx_d;
            r_drain_q     <= w_drain_d;
            r_gate_q      <= w_gate_d;
            r_bram_en_q   <= w_bram_en_d;
            r_bram_addr_q <= w_bram_addr_d;
            r_tag_q       <= w_tag_d;
            r_acc_q       <= w_acc_d;
            r_mix_q       <= w_mix_d;
            r_mix_valid_q <= w_mix_valid_d;
            r_busy_q      <= w_busy_d;
            r_overrun_q   <= w_overrun_d;
        end
    end

    assign bram_en   = r_bram_en_q;
    assign bram_addr = r_bram_addr_q;
    assign mix_out   = r_mix_q;
    assign mix_valid = r_mix_valid_q;
    assign busy      = r_busy_q;
    assign overrun   = r_overrun_q;

endmodule : sample_voice_sequencer
`default_nettype wire
